// File: rtl/byte_packer_pkg.sv
// Shared widths, lane word type and fill-state enum for byte_packer.
// Lane 0 of word_t is the most significant byte of the packed word.
package byte_packer_pkg;

  localparam int BYTE_W = 8;
  localparam int LANES  = 4;
  localparam int CNT_W  = $clog2(LANES);

  typedef logic [0:LANES-1][BYTE_W-1:0] word_t;

  typedef enum logic {
    FILLING,
    STALLED
  } fill_state_t;

  // Keep the first n lanes of w and replace the remaining lanes with the pad byte.
  function automatic word_t pad_word(word_t w, logic [CNT_W:0] n, logic [BYTE_W-1:0] fill);
    word_t r;
    for (int i = 0; i < LANES; i++) begin
      r[i] = (i < int'(n)) ? w[i] : fill;
    end
    return r;
  endfunction

endpackage

// File: rtl/byte_packer_nearest_idx.sv
// nearest_idx_sel: picks the lane closest to the word's average byte value.
// Only compiled when BYTE_PACKER_NEAREST_IDX_EN is defined.
`ifdef BYTE_PACKER_NEAREST_IDX_EN
module nearest_idx_sel
  import byte_packer_pkg::*;
(
  input  word_t      word,
  output logic [1:0] idx
);

  localparam int DW = 12;

  logic [DW-1:0]          sum;
  logic signed [DW-1:0]   diff;
  logic signed [2*DW-1:0] dext;
  logic [2*DW-1:0]        sq [LANES];
  logic [2*DW-1:0]        best;

  // Comparing 4*lane against the sum avoids a divide; strict < keeps the lowest index on ties.
  always_comb begin
    sum  = '0;
    diff = '0;
    dext = '0;
    for (int i = 0; i < LANES; i++) begin
      sum = sum + DW'(word[i]);
    end
    for (int i = 0; i < LANES; i++) begin
      diff  = $signed(DW'({word[i], 2'b00})) - $signed(sum);
      dext  = (2*DW)'(diff);
      sq[i] = $unsigned(dext * dext);
    end
    idx  = 2'd0;
    best = sq[0];
    for (int i = 1; i < LANES; i++) begin
      if (sq[i] < best) begin
        best = sq[i];
        idx  = 2'(i);
      end
    end
  end

endmodule
`endif

// File: rtl/byte_packer.sv
// byte_packer: packs a byte stream into 32-bit words, with flush of partial words.
// Define BYTE_PACKER_NEAREST_IDX_EN to enable the dout_idx nearest-to-average output.
module byte_packer
  import byte_packer_pkg::*;
#(
  parameter logic [BYTE_W-1:0] FILL = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        flush,
  output logic [31:0] dout,
  output logic [2:0]  dout_count,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [1:0]  dout_idx
);

  fill_state_t      state;
  logic [CNT_W-1:0] cnt;
  word_t            acc;
  word_t            dout_q;
  logic [CNT_W:0]   dout_count_q;
  logic             dout_valid_q;
  logic             pend;

  logic             out_free;
  logic             accept;
  logic             full;
  logic             load;
  logic [CNT_W:0]   cnt_a;
  logic [CNT_W-1:0] cnt_n;
  word_t            acc_a;
  word_t            word_n;
  logic             valid_n;

  assign out_free   = !dout_valid_q || dout_ready;
  // STALLED is kept equal to (cnt==3 && word held), so this is !(cnt==3 && !out_free).
  assign din_ready  = !(state == STALLED && !dout_ready);
  assign accept     = din_valid && din_ready;

  assign dout       = dout_q;
  assign dout_count = dout_count_q;
  assign dout_valid = dout_valid_q;

  // The byte accepted this cycle lands first, so a flush sees it and a fourth byte wins outright.
  always_comb begin
    acc_a = acc;
    if (accept) begin
      acc_a[cnt] = din;
    end
    cnt_a   = {1'b0, cnt} + {{CNT_W{1'b0}}, accept};
    full    = accept && (cnt == CNT_W'(LANES - 1));
    load    = out_free && (full || (pend && (cnt_a != '0)));
    word_n  = pad_word(acc_a, cnt_a, FILL);
    cnt_n   = load ? '0 : cnt_a[CNT_W-1:0];
    valid_n = load || (dout_valid_q && !dout_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILLING;
      cnt          <= '0;
      acc          <= '0;
      pend         <= 1'b0;
      dout_q       <= '0;
      dout_count_q <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      cnt          <= cnt_n;
      acc          <= load ? '0 : acc_a;
      dout_valid_q <= valid_n;
      if (load) begin
        dout_q       <= word_n;
        dout_count_q <= cnt_a;
      end
      if (flush) begin
        pend <= 1'b1;
      end else if (load || (cnt_a == '0)) begin
        pend <= 1'b0;
      end
      state <= ((cnt_n == CNT_W'(LANES - 1)) && valid_n) ? STALLED : FILLING;
    end
  end

`ifdef BYTE_PACKER_NEAREST_IDX_EN
  logic [1:0] idx_n;
  logic [1:0] idx_q;

  nearest_idx_sel u_nearest_idx_sel (
    .word (word_n),
    .idx  (idx_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= 2'd0;
    end else if (load) begin
      idx_q <= idx_n;
    end
  end

  assign dout_idx = idx_q;
`else
  assign dout_idx = 2'd0;
`endif

endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 SHALL have parameter FILL, default 8'h00: pad byte placed in unused lanes of a flushed partial word.
REQ-002 SHALL have clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have din  input  8  byte from producer.
REQ-005 SHALL have din_valid  input  1  din holds a byte.
REQ-006 SHALL have din_ready  output  1  block accepts din this cycle.
REQ-007 SHALL have flush  input  1  single-cycle request to emit the current partial word.
REQ-008 SHALL have dout  output  32  packed word; first byte in [31:24], fourth in [7:0].
REQ-009 SHALL have dout_count  output  3  valid bytes in dout, 1..4.
REQ-010 SHALL have dout_valid  output  1  dout/dout_count are valid.
REQ-011 SHALL have dout_ready  input  1  consumer takes dout this cycle.
REQ-012 SHALL have dout_idx  output  2  nearest-to-average lane index; present only per REQ-027.

Function
REQ-013 SHALL accept a byte when din_valid && din_ready, writing it to lane cnt of an accumulator (lane 0 = [31:24]); cnt is 0..3.
REQ-014 SHALL complete a word when the accepted byte is the fourth, loading the output register with dout_count=4 and asserting dout_valid on the next cycle (latency 1), and SHALL reset cnt to 0.
REQ-015 SHALL hold dout, dout_count and dout_valid stable until dout_valid && dout_ready; dout_valid drops the next cycle unless a new word loads in the same cycle.
REQ-016 SHALL treat the output register as free when !dout_valid || dout_ready.
REQ-017 SHALL drive din_ready = !(cnt==3 && !output free), so up to 3 bytes accumulate while a word is held.
REQ-018 SHALL register flush into a pending flag; it is honoured on the first cycle the output register is free and cnt>0 (counting a byte accepted that cycle).
REQ-019 SHALL, on a honoured flush, load lanes 0..cnt-1 with accumulated bytes, remaining lanes with FILL, dout_count=cnt, then clear cnt and the pending flag.
REQ-020 SHALL ignore and clear a flush when cnt==0 with no byte accepted that cycle.
REQ-021 SHALL apply a byte accepted in the same cycle as a honoured flush first; a resulting fourth byte yields a normal full word and consumes the flush.
REQ-022 SHALL use a two-state machine per lane fill: FILLING (cnt 0..3), STALLED (cnt==3, output not free, din_ready=0); STALLED returns to FILLING when the output frees.

Reset
REQ-023 SHALL, on rst, clear cnt, accumulator, pending flush, output register, dout_count and dout_idx to 0, and drive dout_valid=0.
REQ-024 SHALL drive din_ready=1 in the cycle after rst deasserts.
REQ-025 SHALL discard any partial word or held output on rst asserted mid-operation, with no output emitted for it.

Configuration
REQ-026 SHALL compile the nearest-to-average index feature only when macro BYTE_PACKER_NEAREST_IDX_EN is defined.
REQ-027 SHALL, with the macro, load dout_idx with the output word: lane i minimising (4*lane_i - sum of four lanes)^2, using unsigned lane values with at least 11-bit signed difference, lowest index on ties, FILL lanes included; without the macro, tie dout_idx to 0.

Structure
REQ-028 SHALL take BYTE_W=8, LANES=4 and the cnt width from shared package byte_packer_pkg.
REQ-029 SHALL place the index computation in combinational sub-module nearest_idx_sel, instantiated only under the macro.

Verification
REQ-030 SHALL test bytes 10,20,30,40 hex back-to-back, dout_ready=1 -> dout=0x10203040, count=4, valid one cycle after the fourth byte; with macro dout_idx=1.
REQ-031 SHALL test bytes AA,BB then flush, FILL=00 -> dout=0xAABB0000, count=2.
REQ-032 SHALL test dout_ready=0, 8 bytes offered -> 7 accepted, din_ready=0 at the 8th; one cycle of dout_ready -> 8th accepted, second word valid next cycle.
REQ-033 SHALL test flush with cnt=0 -> no output; flush in the same cycle as the 4th byte -> one full word only.
REQ-034 SHALL test rst after 2 bytes, then 11,22,33,44 -> dout=0x11223344 with no stale bytes.
